// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scan codes, grid Direction one-hot codes and FSM state encodings.
//   Contents: scan-code localparams, DIR_* codes, rx_state_t, dec_state_t, arrow_dir().
package ps2_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;
  function automatic logic [3:0] arrow_dir(input logic [7:0] code);
    return code == SC_UP    ? DIR_UP   :
           code == SC_DOWN  ? DIR_DOWN :
           code == SC_LEFT  ? DIR_LEFT :
           code == SC_RIGHT ? DIR_RIGHT : DIR_NONE;
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver (synchronisers, clock filter, rx FSM, mid-frame timeout).
//   CLOCK_50/nReset : system clock, async active-low reset
//   ps2_clk/ps2_dat : raw keyboard pins
//   rx_byte         : received data byte (valid while byte_valid is high)
//   byte_valid      : 1-cycle pulse on the stop strobe of an accepted frame
//   byte_err        : 1-cycle pulse on the stop strobe of a rejected frame
//   timeout         : 1-cycle pulse when a stalled frame is aborted
//   PS2_PARITY_CHECK_EN: when defined, frames need odd parity and stop = 1.
module ps2_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       nReset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       timeout
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  rx_state_t state, state_n;
  logic [1:0] clk_sync, dat_sync;
  logic clk_filt;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic strobe, sdat, stop_done;
  assign sdat = dat_sync[1];
  // The strobe fires on the very cycle the filtered clock commits to low.
  assign strobe = clk_filt && !clk_sync[1] && fcnt == FMAX;
  // A stop strobe landing on the timeout cycle suppresses the timeout.
  assign timeout = state != RX_IDLE && tcnt == TMAX && !strobe;
  assign stop_done = strobe && state == RX_STOP;
  assign rx_byte = shreg;
`ifdef PS2_PARITY_CHECK_EN
  logic parity;
  logic frame_ok;
  assign frame_ok = (^{parity, shreg}) && sdat;
  assign byte_valid = stop_done && frame_ok;
  assign byte_err = stop_done && !frame_ok;
  always_ff @(posedge CLOCK_50 or negedge nReset)
    if (!nReset) parity <= 1'b0;
    else if (strobe && state == RX_PARITY) parity <= sdat;
`else
  assign byte_valid = stop_done;
  assign byte_err = 1'b0;
`endif
  always_ff @(posedge CLOCK_50 or negedge nReset)
    if (!nReset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      if (clk_sync[1] == clk_filt) fcnt <= '0;
      else if (fcnt == FMAX) begin
        clk_filt <= clk_sync[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  always_comb begin
    state_n = state;
    if (strobe)
      state_n = state == RX_IDLE   ? (sdat ? RX_IDLE : RX_DATA) :
                state == RX_DATA   ? (bit_cnt == 3'd7 ? RX_PARITY : RX_DATA) :
                state == RX_PARITY ? RX_STOP : RX_IDLE;
    else if (timeout) state_n = RX_IDLE;
  end
  always_ff @(posedge CLOCK_50 or negedge nReset)
    if (!nReset) begin
      state <= RX_IDLE;
      tcnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      tcnt <= (state == RX_IDLE || strobe || timeout) ? '0 : tcnt + 1'b1;
      if (strobe) bit_cnt <= state == RX_DATA ? bit_cnt + 1'b1 : 3'd0;
      if (strobe && state == RX_DATA) shreg <= {sdat, shreg[7:1]};
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 keyboard to grid-control levels (arrows, SPACE/ENTER).
//   CLOCK_50/nReset  : system clock, async active-low reset
//   PS2_CLK/PS2_DAT  : raw keyboard pins (idle high)
//   Direction        : one-hot held arrow, 0 = none
//   Command          : high while SPACE or ENTER is held
//   scan_code        : last received byte
//   scan_valid       : 1-cycle pulse when scan_code updates
//   frame_err        : 1-cycle pulse on a rejected frame
//   PS2_PARITY_CHECK_EN: when defined, bad parity/stop frames are rejected.
module ps2_key_decoder import ps2_pkg::*; #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       nReset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [3:0] Direction,
  output logic       Command,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);
  logic [7:0] rx_byte;
  logic byte_valid, byte_err, timeout;
  dec_state_t dstate, dstate_n;
  logic [3:0] dir_n, arrow;
  logic cmd_n, ext, brk, cmd_key;
  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .CLOCK_50  (CLOCK_50),
    .nReset    (nReset),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .timeout   (timeout)
  );
  assign ext = dstate == DEC_EXT || dstate == DEC_EXT_BRK;
  assign brk = dstate == DEC_BRK || dstate == DEC_EXT_BRK;
  // Arrows only exist with the E0 prefix; bare 75/72/6B/74 are keypad keys.
  assign arrow = ext ? arrow_dir(rx_byte) : DIR_NONE;
  assign cmd_key = !ext && (rx_byte == SC_SPACE || rx_byte == SC_ENTER);
  always_comb begin
    dstate_n = dstate;
    dir_n = Direction;
    cmd_n = Command;
    if (timeout || byte_err) dstate_n = DEC_BASE;
    else if (byte_valid) begin
      if (dstate == DEC_BASE && rx_byte == SC_EXT) dstate_n = DEC_EXT;
      else if (!brk && rx_byte == SC_BRK) dstate_n = ext ? DEC_EXT_BRK : DEC_BRK;
      else begin
        dstate_n = DEC_BASE;
        // A break only releases the arrow that is currently shown.
        if (arrow != DIR_NONE) dir_n = brk ? (Direction == arrow ? DIR_NONE : Direction) : arrow;
        if (cmd_key) cmd_n = !brk;
      end
    end
  end
  always_ff @(posedge CLOCK_50 or negedge nReset)
    if (!nReset) begin
      dstate <= DEC_BASE;
      Direction <= DIR_NONE;
      Command <= 1'b0;
      scan_code <= '0;
      scan_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dstate <= dstate_n;
      Direction <= dir_n;
      Command <= cmd_n;
      scan_valid <= byte_valid;
      frame_err <= byte_err;
      if (byte_valid) scan_code <= rx_byte;
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed, table-driven check of the PS/2 key decoder.
module tb_ps2_key_decoder;
  localparam int HALF = 20;
  logic CLOCK_50 = 1'b0;
  logic nReset = 1'b0;
  logic PS2_CLK = 1'b1;
  logic PS2_DAT = 1'b1;
  logic [3:0] Direction;
  logic Command, scan_valid, frame_err;
  logic [7:0] scan_code;
  int n_chk = 0, n_fail = 0, n_valid = 0, n_err = 0;
  int v0, e0;
  typedef struct {logic [7:0] code; logic [3:0] dir; logic cmd;} vec_t;
  vec_t tbl[22];

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(5000)) dut (
    .CLOCK_50  (CLOCK_50),
    .nReset    (nReset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .Direction (Direction),
    .Command   (Command),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always @(negedge CLOCK_50) begin
    if (scan_valid) n_valid++;
    if (frame_err) n_err++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    wait_cyc(HALF);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    tbl = '{
      '{8'hE0, 4'b0000, 1'b0}, '{8'h75, 4'b0001, 1'b0},
      '{8'hE0, 4'b0001, 1'b0}, '{8'hF0, 4'b0001, 1'b0}, '{8'h75, 4'b0000, 1'b0},
      '{8'hE0, 4'b0000, 1'b0}, '{8'h6B, 4'b0100, 1'b0},
      '{8'hE0, 4'b0100, 1'b0}, '{8'h74, 4'b1000, 1'b0},
      '{8'hE0, 4'b1000, 1'b0}, '{8'hF0, 4'b1000, 1'b0}, '{8'h6B, 4'b1000, 1'b0},
      '{8'h75, 4'b1000, 1'b0},
      '{8'hE0, 4'b1000, 1'b0}, '{8'hF0, 4'b1000, 1'b0}, '{8'h74, 4'b0000, 1'b0},
      '{8'h29, 4'b0000, 1'b1}, '{8'h29, 4'b0000, 1'b1}, '{8'h29, 4'b0000, 1'b1},
      '{8'hF0, 4'b0000, 1'b1}, '{8'h29, 4'b0000, 1'b0},
      '{8'h1C, 4'b0000, 1'b0}
    };
    wait_cyc(5);
    chk("reset Direction", 32'(Direction), 32'h0);
    chk("reset Command", 32'(Command), 32'h0);
    chk("reset scan_code", 32'(scan_code), 32'h0);
    chk("reset scan_valid", 32'(scan_valid), 32'h0);
    chk("reset frame_err", 32'(frame_err), 32'h0);
    nReset = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < 22; i++) begin
      v0 = n_valid;
      send(tbl[i].code);
      chk($sformatf("vec%0d scan_code", i), 32'(scan_code), 32'(tbl[i].code));
      chk($sformatf("vec%0d Direction", i), 32'(Direction), 32'(tbl[i].dir));
      chk($sformatf("vec%0d Command", i), 32'(Command), 32'(tbl[i].cmd));
      chk($sformatf("vec%0d pulses", i), 32'(n_valid - v0), 32'd1);
    end

    // Stalled frame: 4 data bits of 5A, then silence beyond the timeout.
    v0 = n_valid;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i == 1 || i == 3);
    wait_cyc(6000);
    chk("timeout no pulse", 32'(n_valid - v0), 32'd0);
    chk("timeout Command held", 32'(Command), 32'h0);
    send(8'h5A);
    chk("after timeout scan_code", 32'(scan_code), 32'h5A);
    chk("after timeout Command", 32'(Command), 32'h1);
    chk("after timeout pulses", 32'(n_valid - v0), 32'd1);
    send(8'hF0);
    send(8'h5A);
    chk("enter break Command", 32'(Command), 32'h0);

    // Bad parity frame.
    v0 = n_valid;
    e0 = n_err;
    send(8'h5A, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk("bad parity frame_err pulses", 32'(n_err - e0), 32'd1);
    chk("bad parity no valid", 32'(n_valid - v0), 32'd0);
    chk("bad parity Command", 32'(Command), 32'h0);
    send(8'h5A);
    chk("good parity Command", 32'(Command), 32'h1);
    chk("good parity no frame_err", 32'(n_err - e0), 32'd1);
`else
    chk("parity ignored frame_err", 32'(n_err - e0), 32'd0);
    chk("parity ignored valid", 32'(n_valid - v0), 32'd1);
    chk("parity ignored Command", 32'(Command), 32'h1);
`endif
    send(8'hF0);
    send(8'h5A);
    chk("post parity Command", 32'(Command), 32'h0);

    // Reset in the middle of an E0,75 sequence.
    send(8'h29);
    chk("pre reset Command", 32'(Command), 32'h1);
    send(8'hE0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    nReset = 1'b0;
    wait_cyc(3);
    chk("mid reset Direction", 32'(Direction), 32'h0);
    chk("mid reset Command", 32'(Command), 32'h0);
    chk("mid reset scan_code", 32'(scan_code), 32'h0);
    chk("mid reset scan_valid", 32'(scan_valid), 32'h0);
    PS2_DAT = 1'b1;
    wait_cyc(5);
    nReset = 1'b1;
    wait_cyc(5);
    send(8'hE0);
    send(8'h75);
    chk("post reset Direction", 32'(Direction), 32'h1);
    chk("post reset scan_code", 32'(scan_code), 32'h75);
`ifndef PS2_PARITY_CHECK_EN
    chk("frame_err never", 32'(n_err), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
